// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus initiator: access size codes,
// bus direction constants, the transaction state encoding and the
// alignment rule used to reject an access before it reaches the bus.
package mem_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        GAP,
        WR,
        DONE
    } state_t;

    // Size code 3 has no meaning on this bus, so it is rejected like a
    // misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between the CPU view (right-aligned
// data) and the word-wide bus view.
//   size_i     : access size code
//   unsigned_i : zero-extend sub-word loads when high
//   lane_i     : byte address bits [1:0]
//   rword_i    : word captured from the bus read
//   wdata_i    : right-aligned store data
//   load_o     : extracted and extended load result
//   store_o    : word to write back (merged for sub-word stores)
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [4:0]  sh;
    logic [31:0] shifted;

    assign sh      = {lane_i, 3'b000};
    assign shifted = rword_i >> sh;

    always_comb begin
        load_o  = rword_i;
        store_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
                store_o = (rword_i & ~(32'h0000_00FF << sh))
                        | ({24'h0, wdata_i[7:0]} << sh);
            end
            SZ_HALF: begin
                // Half accesses are aligned, so sh is 0 or 16 here.
                load_o  = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
                store_o = (rword_i & ~(32'h0000_FFFF << sh))
                        | ({16'h0, wdata_i[15:0]} << sh);
            end
            default: begin
                load_o  = rword_i;
                store_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator between the CPU load/store stage and the synchronous
// memory. Handles one byte/half/word access at a time, polls wait_sig,
// performs read-modify-write for sub-word stores and reports misaligned
// or timed-out accesses through resp_err.
//   clk, rst_n           : clock, synchronous active-low reset
//   req_*                : CPU request (valid/ready handshake)
//   resp_*               : one-cycle completion pulse with data/error
//   enable, rw, address,
//   write_data           : bus command outputs
//   wait_sig, read_data  : bus responses from memory
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        enable,
    output logic        rw,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic        wait_sig,
    input  logic [31:0] read_data
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t      state_q, state_d;
    logic        rdy_q;
    logic        seen_q, seen_d;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        capture;
    logic        bus_done;
    logic        bus_tmo;
    logic [31:0] load_word;
    logic [31:0] store_word;

    mem_lane_align u_align (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .lane_i     (addr_q[1:0]),
        .rword_i    (rdata_q),
        .wdata_i    (wdata_q),
        .load_o     (load_word),
        .store_o    (store_word)
    );

    assign accept   = req_valid && req_ready;
    // Completion needs a busy cycle first, so a stale low wait_sig from
    // the previous access cannot end this one.
    assign bus_done = seen_q && !wait_sig;
    assign bus_tmo  = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            seen_q  <= seen_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request and read-data holding registers; outputs are gated by
    // state, so these need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (capture) begin
            rdata_q <= read_data;
        end
    end

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    seen_d = 1'b0;
                    cnt_d  = '0;
                    err_d  = is_misaligned(req_size, req_addr[1:0]);
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = DONE;
                    end else if (req_we && req_size == SZ_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (bus_done) begin
                    capture = 1'b1;
                    // Only sub-word stores pass through RD with we set.
                    state_d = we_q ? GAP : DONE;
                end else if (bus_tmo) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (wait_sig) begin
                        seen_d = 1'b1;
                    end
                end
            end
            GAP: begin
                seen_d  = 1'b0;
                cnt_d   = '0;
                state_d = WR;
            end
            WR: begin
                if (bus_done) begin
                    state_d = DONE;
                end else if (bus_tmo) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (wait_sig) begin
                        seen_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE) && rdy_q;
    assign enable     = (state_q == RD) || (state_q == WR);
    assign rw         = (state_q == WR) ? RW_WRITE : RW_READ;
    assign address    = enable ? {addr_q[31:2], 2'b00} : 32'h0;
    assign write_data = (state_q == WR) ? store_word : 32'h0;
    assign resp_valid = (state_q == DONE);
    assign resp_err   = (state_q == DONE) && err_q;
    assign resp_rdata = ((state_q == DONE) && !err_q && !we_q) ? load_word : 32'h0;

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

    localparam int MEM_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, enable, rw, wait_sig;
    logic [31:0] resp_rdata, address, write_data, read_data;

    logic        t_req_valid = 1'b0;
    logic        t_wait = 1'b0;
    logic [31:0] t_rdata_in = 32'h0;
    logic        t_req_ready, t_resp_valid, t_resp_err, t_enable, t_rw;
    logic [31:0] t_resp_rdata, t_address, t_write_data;

    always #5 clk = ~clk;

    mem_bus_master u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .enable(enable), .rw(rw), .address(address), .write_data(write_data),
        .wait_sig(wait_sig), .read_data(read_data)
    );

    mem_bus_master #(.TIMEOUT(8)) u_t8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
        .enable(t_enable), .rw(t_rw), .address(t_address), .write_data(t_write_data),
        .wait_sig(t_wait), .read_data(t_rdata_in)
    );

    // Memory model: busy for MEM_WAIT cycles after enable rises, then one
    // ready cycle in which reads are valid and writes commit.
    logic [31:0] mem [0:1023];
    int          wcnt = 0;
    assign wait_sig  = enable && (wcnt < MEM_WAIT);
    assign read_data = mem[address[11:2]];

    always @(posedge clk) begin
        if (!enable) wcnt <= 0;
        else if (wcnt < MEM_WAIT) wcnt <= wcnt + 1;
        if (enable && rw && !wait_sig) mem[address[11:2]] <= write_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;
    exp_t sb[$];

    // Bus activity trace: burst starts and read->gap->write patterns.
    int   rd_bursts = 0, wr_bursts = 0, gaps = 0, en_in_done = 0;
    logic p1_en = 1'b0, p2_en = 1'b0, p2_rw = 1'b0;
    always @(negedge clk) begin
        if (enable && !p1_en) begin
            if (rw) begin
                wr_bursts++;
                if (p2_en && !p2_rw) gaps++;
            end else begin
                rd_bursts++;
            end
        end
        if (enable && resp_valid) en_in_done++;
        p2_en = p1_en;
        p2_rw = rw;
        p1_en = enable;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_rdata"}, resp_rdata, e.rd);
                chk({e.nm, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
                chk({e.nm, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic do_req(input string nm, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input bit push);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk({nm, "_ready_wait"}, 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{exp_rd, exp_err, exp_lat, cyc, nm});
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((sb.size() != 0 || !req_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) chk("resp_wait", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int r0, w0, g0, en_cnt, acc;
        bit got;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h200 >> 2] = 32'h80F0_017F;
        mem[32'h300 >> 2] = 32'h1122_3344;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
        chk("rst_enable", {31'h0, enable}, 32'd0);
        chk("rst_rw", {31'h0, rw}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, req_ready}, 32'd1);

        // Word store then word load.
        do_req("sw100", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 18, 1'b1);
        wait_idle();
        chk("mem_100", mem[32'h100 >> 2], 32'hDEAD_BEEF);
        do_req("lw100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 18, 1'b1);
        wait_idle();

        // Sub-word loads with sign/zero extension.
        do_req("lb203", 1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'hFFFF_FF80, 1'b0, 18, 1'b1);
        do_req("lbu203", 1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'h0000_0080, 1'b0, 18, 1'b1);
        do_req("lh200", 1'b0, 2'd1, 1'b0, 32'h200, 32'h0, 32'h0000_017F, 1'b0, 18, 1'b1);
        do_req("lh202", 1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'hFFFF_80F0, 1'b0, 18, 1'b1);
        do_req("lhu202", 1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'h0000_80F0, 1'b0, 18, 1'b1);
        wait_idle();

        // Read-modify-write byte store, then half store.
        r0 = rd_bursts; w0 = wr_bursts; g0 = gaps;
        do_req("sb301", 1'b1, 2'd0, 1'b0, 32'h301, 32'h0000_00AA, 32'h0, 1'b0, 36, 1'b1);
        wait_idle();
        chk("mem_300_sb", mem[32'h300 >> 2], 32'h1122_AA44);
        chk("rmw_reads", 32'(rd_bursts - r0), 32'd1);
        chk("rmw_writes", 32'(wr_bursts - w0), 32'd1);
        chk("rmw_gap", 32'(gaps - g0), 32'd1);
        do_req("sh302", 1'b1, 2'd1, 1'b0, 32'h302, 32'h1234_BEEF, 32'h0, 1'b0, 36, 1'b1);
        wait_idle();
        chk("mem_300_sh", mem[32'h300 >> 2], 32'hBEEF_AA44);

        // Misaligned accesses never reach the bus.
        r0 = rd_bursts; w0 = wr_bursts;
        do_req("lh101", 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        do_req("sw102", 1'b1, 2'd2, 1'b0, 32'h102, 32'h5555_5555, 32'h0, 1'b1, 1, 1'b1);
        do_req("sz3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        wait_idle();
        chk("mis_no_bus", 32'(rd_bursts - r0 + wr_bursts - w0), 32'd0);
        chk("mis_mem_100", mem[32'h100 >> 2], 32'hDEAD_BEEF);

        // Timeout on the TIMEOUT=8 instance with wait_sig tied low.
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40;
        t_req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        t_req_valid = 1'b0;
        en_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (t_resp_valid) begin
                got = 1'b1;
                chk("tmo_err", {31'h0, t_resp_err}, 32'd1);
                chk("tmo_rdata", t_resp_rdata, 32'd0);
                chk("tmo_en_done", {31'h0, t_enable}, 32'd0);
                chk("tmo_lat", 32'(cyc - acc + 1), 32'd9);
                chk("tmo_bus_cycles", 32'(en_cnt), 32'd8);
            end else if (t_enable) begin
                en_cnt++;
            end
        end
        if (!got) chk("tmo_resp_wait", 32'd0, 32'd1);

        // Reset in the middle of a read.
        do_req("lw_abort", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_in_rd", {31'h0, enable}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_enable", {31'h0, enable}, 32'd0);
        chk("abort_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("abort_req_ready", {31'h0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req("lw300_post", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'hBEEF_AA44, 1'b0, 18, 1'b1);
        wait_idle();

        chk("enable_in_done", 32'(en_in_done), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Initiator side of the word-wide memory bus (enable / rw / address / write_data / wait_sig / read_data) served by the synchronous memory model. It sits between the CPU load/store stage and the memory. It accepts one byte, halfword or word access at a time and drives the bus handshake, including wait-state polling. Sub-word stores use read-modify-write; loads return sign- or zero-extended data. Misaligned addresses and bus timeouts are reported as errors.

## Interface
- `TIMEOUT`, default 64: maximum bus cycles per transaction before it is aborted with an error.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: CPU access request.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid` and `req_ready` are both high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as misaligned.
- `req_unsigned` in 1: zero-extend sub-word loads when high; sign-extend when low.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (bits [7:0] for a byte).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result, valid while `resp_valid` is high; 0 for stores and errors.
- `resp_err` out 1: valid while `resp_valid` is high; set for misalignment or timeout.
- `enable` out 1: bus select.
- `rw` out 1: bus direction, 0 = read, 1 = write.
- `address` out 32: bus address, always word-aligned, `{addr[31:2],2'b00}`.
- `write_data` out 32: bus write word.
- `wait_sig` in 1: memory busy indication.
- `read_data` in 32: memory read word.

## Operation
- States and transitions:
  - IDLE: on accept, go to DONE if misaligned, else to WR (word store), RD (load or sub-word store).
  - RD: go to GAP on sub-word store done, else to DONE.
  - GAP: one cycle, go to WR.
  - WR: go to DONE.
  - DONE: go to IDLE.
- Accept latches `req_we`, `req_size`, `req_unsigned`, `req_addr` and `req_wdata` into internal registers. Request inputs are ignored outside IDLE.
- Misaligned conditions:
  - half with `addr[0]=1`;
  - word with `addr[1:0]!=0`;
  - size 3.
  - A misaligned access makes no bus access and responds with `resp_err=1`.
- Bus transaction (RD/WR):
  - `enable=1`, with `rw`, `address` and `write_data` held constant for the whole state.
  - Completion is the first cycle in which `wait_sig` is low, after `wait_sig` has been sampled high at least once since the state was entered. A `seen_busy` flag is cleared on state entry.
  - `read_data` is captured in the completion cycle.
- Timeout:
  - A cycle counter is cleared on RD/WR entry.
  - When the counter reaches `TIMEOUT-1` without completion, go to DONE with `resp_err=1`. No write phase follows a timed-out RMW read.
- Lane select: `sh = addr[1:0]*8`.
  - Byte load: `read_data[sh+:8]`, extended to 32 bits.
  - Half load: `read_data[sh+:16]`, extended to 32 bits.
- Store merge:
  - Byte store replaces lane `addr[1:0]` of the captured word with `wdata[7:0]`.
  - Half store replaces lane `addr[1]` (bits [15:0] or [31:16]) with `wdata[15:0]`.
  - Other bytes are preserved.
- GAP drives `enable=0` for one cycle so the memory's wait counter restarts.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `enable=0`, `rw=0`, `address=0`, `write_data=0`; state = IDLE.
- `req_ready` goes to 1 on the first cycle after reset release.
- Accept at edge N puts `enable=1` during cycle N+1.
- `resp_valid` is high exactly one cycle, in DONE. `req_ready` returns high the following cycle, so back-to-back accesses are separated by ≥1 idle cycle.
- Load latency, with W = bus cycles to completion: accept + W + 1 (DONE).
- Sub-word store latency: accept + W_rd + 1 (GAP) + W_wr + 1.
- Misaligned access: response in the cycle after accept.
- `enable` is never high in IDLE, GAP or DONE.
- Reset asserted mid-transaction: all outputs return to reset values at the next edge, with no response pulse.

## Structure
- Shared package `mem_bus_pkg`:
  - size codes `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum (IDLE, RD, GAP, WR, DONE);
  - `RW_READ`, `RW_WRITE` constants.
- One natural sub-module, `mem_lane_align`, which is combinational and contains load extraction/extension and store merge.
- The FSM, timeout counter and `seen_busy` flag stay in the top module.

## Test plan
- Word store then load:
  - Store `0xDEADBEEF` to `0x100`; memory word 64 becomes `0xDEADBEEF`; `resp_err=0`.
  - Load word `0x100` returns `0xDEADBEEF` after the memory's 16-cycle wait.
- Byte loads from word `0x80F0017F` at `0x200`:
  - Signed byte at `0x203` gives `0xFFFFFF80`.
  - Unsigned byte at `0x203` gives `0x00000080`.
  - Signed half at `0x200` gives `0x0000017F`.
- RMW store:
  - Memory word `0x11223344` at `0x300`; store byte `0xAA` to `0x301`.
  - Memory word becomes `0x1122AA44`.
  - Observe one bus read, one cycle with `enable=0`, then one bus write.
- Misaligned:
  - Half load at `0x101` and word store at `0x102`: each gives `resp_valid` one cycle after accept with `resp_err=1`.
  - `enable` stays 0 and memory is unchanged.
- Timeout: with `TIMEOUT=8`, tie `wait_sig` to 0; `resp_err=1` after 8 bus cycles, and `enable` drops in DONE.
- Reset mid-op: assert `rst_n=0` during RD; next edge gives `enable=0` and `resp_valid=0`. After release, a new word load completes normally.
